geri_yaz: RTL

//  Write-back stage directly downstream of the memory stage. Retires one uop per

---
 rtl/geri_yaz_if.sv | 40 ++++
 rtl/geri_yaz.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/geri_yaz_if.sv
// Memory-stage -> write-back bundle: uop issue, L1 read-data handshake, stall and
// register-file write port of the write-back stage.
interface geri_yaz_if #(
  parameter int VERI_BIT = 32,
  parameter int RD_BIT   = 5,
  parameter int TAG_BIT  = 4
) ();
  logic                uop_gecerli_i;
  logic [TAG_BIT-1:0]  uop_tag_i;
  logic [RD_BIT-1:0]   uop_rd_i;
  logic                uop_yaz_i;
  logic                uop_yuk_i;
  logic [2:0]          uop_yuk_tur_i;
  logic [1:0]          uop_adres_lsb_i;
  logic [VERI_BIT-1:0] uop_sonuc_i;
  logic [VERI_BIT-1:0] l1v_veri_i;
  logic                l1v_veri_gecerli_i;
  logic                l1v_veri_hazir_o;
  logic                duraklat_o;
  logic                yaz_gecerli_o;
  logic [RD_BIT-1:0]   yaz_adres_o;
  logic [VERI_BIT-1:0] yaz_veri_o;
  logic [TAG_BIT-1:0]  yaz_tag_o;

  modport slave (
    input  uop_gecerli_i, uop_tag_i, uop_rd_i, uop_yaz_i, uop_yuk_i,
           uop_yuk_tur_i, uop_adres_lsb_i, uop_sonuc_i,
           l1v_veri_i, l1v_veri_gecerli_i,
    output l1v_veri_hazir_o, duraklat_o,
           yaz_gecerli_o, yaz_adres_o, yaz_veri_o, yaz_tag_o
  );

  modport master (
    output uop_gecerli_i, uop_tag_i, uop_rd_i, uop_yaz_i, uop_yuk_i,
           uop_yuk_tur_i, uop_adres_lsb_i, uop_sonuc_i,
           l1v_veri_i, l1v_veri_gecerli_i,
    input  l1v_veri_hazir_o, duraklat_o,
           yaz_gecerli_o, yaz_adres_o, yaz_veri_o, yaz_tag_o
  );
endinterface

// File: rtl/geri_yaz.sv
// Write-back stage: retires one uop per cycle, completes loads from the L1 data
// response (lane select + extension) and stalls upstream while a load waits.
module geri_yaz #(
  parameter int VERI_BIT = 32,
  parameter int RD_BIT   = 5,
  parameter int TAG_BIT  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  geri_yaz_if.slave   bus
);

  typedef enum logic {BOS = 1'b0, BEKLE = 1'b1} durum_t;

  durum_t              r_durum;
  durum_t              w_durum_next;

  logic [TAG_BIT-1:0]  r_tag;
  logic [RD_BIT-1:0]   r_rd;
  logic                r_yaz;
  logic [2:0]          r_tur;
  logic [1:0]          r_lsb;

  logic                r_yaz_gecerli;
  logic [RD_BIT-1:0]   r_yaz_adres;
  logic [VERI_BIT-1:0] r_yaz_veri;
  logic [TAG_BIT-1:0]  r_yaz_tag;

  logic                w_ret;
  logic                w_yakala;
  logic                w_hazir;
  logic                w_duraklat;
  logic [TAG_BIT-1:0]  w_ret_tag;
  logic [RD_BIT-1:0]   w_ret_rd;
  logic                w_ret_yaz;
  logic [VERI_BIT-1:0] w_ret_veri;

  // Lane select then extend; funct3 codes 2,3,6,7 all deliver the whole word.
  function automatic logic [VERI_BIT-1:0] f_genislet(
    input logic [2:0]          tur,
    input logic [1:0]          lsb,
    input logic [VERI_BIT-1:0] veri
  );
    logic [VERI_BIT-1:0] w_bayt;
    logic [VERI_BIT-1:0] w_yarim;
    w_bayt  = veri >> {lsb, 3'b000};
    w_yarim = veri >> {lsb[1], 4'b0000};
    case (tur)
      3'd0:    return {{(VERI_BIT-8){w_bayt[7]}}, w_bayt[7:0]};
      3'd1:    return {{(VERI_BIT-16){w_yarim[15]}}, w_yarim[15:0]};
      3'd4:    return {{(VERI_BIT-8){1'b0}}, w_bayt[7:0]};
      3'd5:    return {{(VERI_BIT-16){1'b0}}, w_yarim[15:0]};
      default: return veri;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOS;
    end else begin
      r_durum <= w_durum_next;
    end
  end

  always_comb begin
    w_durum_next = r_durum;
    case (r_durum)
      BOS:     if (w_yakala) w_durum_next = BEKLE;
      BEKLE:   if (bus.l1v_veri_gecerli_i) w_durum_next = BOS;
      default: w_durum_next = BOS;
    endcase
  end

  always_comb begin
    w_ret      = 1'b0;
    w_yakala   = 1'b0;
    w_hazir    = 1'b0;
    w_duraklat = 1'b0;
    w_ret_tag  = bus.uop_tag_i;
    w_ret_rd   = bus.uop_rd_i;
    w_ret_yaz  = bus.uop_yaz_i;
    w_ret_veri = bus.uop_sonuc_i;
    case (r_durum)
      BOS: begin
        if (bus.uop_gecerli_i) begin
          if (!bus.uop_yuk_i) begin
            w_ret = 1'b1;
          end else begin
            w_hazir = 1'b1;
            if (bus.l1v_veri_gecerli_i) begin
              w_ret      = 1'b1;
              w_ret_veri = f_genislet(bus.uop_yuk_tur_i, bus.uop_adres_lsb_i, bus.l1v_veri_i);
            end else begin
              w_yakala   = 1'b1;
              w_duraklat = 1'b1;
            end
          end
        end
      end
      BEKLE: begin
        // Upstream inputs are ignored here; only the captured load fields matter.
        w_hazir    = 1'b1;
        w_duraklat = !bus.l1v_veri_gecerli_i;
        w_ret      = bus.l1v_veri_gecerli_i;
        w_ret_tag  = r_tag;
        w_ret_rd   = r_rd;
        w_ret_yaz  = r_yaz;
        w_ret_veri = f_genislet(r_tur, r_lsb, bus.l1v_veri_i);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag <= '0;
      r_rd  <= '0;
      r_yaz <= 1'b0;
      r_tur <= '0;
      r_lsb <= '0;
    end else if (w_yakala) begin
      r_tag <= bus.uop_tag_i;
      r_rd  <= bus.uop_rd_i;
      r_yaz <= bus.uop_yaz_i;
      r_tur <= bus.uop_yuk_tur_i;
      r_lsb <= bus.uop_adres_lsb_i;
    end
  end

  // x0 retirements still move tag/index/data; only the write enable is withheld.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_yaz_gecerli <= 1'b0;
      r_yaz_adres   <= '0;
      r_yaz_veri    <= '0;
      r_yaz_tag     <= '0;
    end else begin
      r_yaz_gecerli <= w_ret && w_ret_yaz && (w_ret_rd != '0);
      if (w_ret) begin
        r_yaz_adres <= w_ret_rd;
        r_yaz_veri  <= w_ret_veri;
        r_yaz_tag   <= w_ret_tag;
      end
    end
  end

  assign bus.l1v_veri_hazir_o = w_hazir;
  assign bus.duraklat_o       = w_duraklat;
  assign bus.yaz_gecerli_o    = r_yaz_gecerli;
  assign bus.yaz_adres_o      = r_yaz_adres;
  assign bus.yaz_veri_o       = r_yaz_veri;
  assign bus.yaz_tag_o        = r_yaz_tag;

endmodule
